// File: rtl/wos_pkg.sv
// Shared definitions for the weighted order-statistic selector: FSM encoding and
// width helpers used to derive the weight-sum/rank width.
package wos_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Weight sum of N WB-bit weights plus one spare bit so rank can exceed the total
   function automatic int sw_calc(input int wb, input int n);
      return wb + clog2(n) + 1;
   endfunction

endpackage

// File: rtl/wos_rank_select_if.sv
// Window/weights/rank request channel and result channel of the rank selector.
interface wos_rank_select_if
   import wos_pkg::*;
#(
   parameter int BITS = 8,
   parameter int N    = 3,
   parameter int WB   = 4
);
   localparam int SW = sw_calc(WB, N);

   logic                in_valid;
   logic                in_ready;
   logic [BITS*N-1:0]   window;
   logic [WB*N-1:0]     weights;
   logic [SW-1:0]       rank;
   logic                out_valid;
   logic                out_ready;
   logic [BITS-1:0]     out_data;
   logic                out_err;

   modport slave (
      input  in_valid, window, weights, rank, out_ready,
      output in_ready, out_valid, out_data, out_err
   );

   modport master (
      output in_valid, window, weights, rank, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/wos_weight_sum.sv
// Combinational sum of N WB-bit weights, each gated by its enable bit.
module wos_weight_sum
   import wos_pkg::*;
#(
   parameter int  N  = 3,
   parameter int  WB = 4,
   localparam int SW = sw_calc(WB, N)
) (
   input  logic [WB*N-1:0] weights_i,
   input  logic [N-1:0]    en_i,
   output logic [SW-1:0]   sum_o
);

   // Masked accumulation; SW bits cannot overflow for N full-scale weights
   always_comb begin
      sum_o = '0;
      for (int i = 0; i < N; i++) begin
         if (en_i[i]) begin
            sum_o = sum_o + SW'(weights_i[WB*i +: WB]);
         end else begin
            sum_o = sum_o;
         end
      end
   end

endmodule

// File: rtl/wos_rank_select.sv
// Weighted order-statistic selector: MSB-first bit-serial radix select over one
// N-sample window, resolving one result bit per cycle.
module wos_rank_select
   import wos_pkg::*;
#(
   parameter int BITS = 8,
   parameter int N    = 3,
   parameter int WB   = 4
) (
   input  logic             clk,
   input  logic             rst,
   wos_rank_select_if.slave bus
);

   localparam int SW = sw_calc(WB, N);
   localparam int CW = (clog2(BITS) < 1) ? 1 : clog2(BITS);

   state_e              state_q, state_d;
   logic [BITS*N-1:0]   window_q, window_d;
   logic [WB*N-1:0]     weights_q, weights_d;
   logic [SW-1:0]       r_q, r_d;
   logic [N-1:0]        active_q, active_d;
   logic [CW-1:0]       bit_idx_q, bit_idx_d;
   logic [BITS-1:0]     result_q, result_d;
   logic [BITS-1:0]     out_data_q, out_data_d;
   logic                out_err_q, out_err_d;

   logic [SW-1:0]       total_s;
   logic [SW-1:0]       z_s;
   logic [N-1:0]        bit_b_s;
   logic [N-1:0]        z_en_s;
   logic [N-1:0]        nz_s;
   logic                bit_res_s;

   // Current bit plane of the stored window and the nonzero-weight mask of the request
   always_comb begin
      bit_b_s = '0;
      nz_s    = '0;
      for (int i = 0; i < N; i++) begin
         bit_b_s[i] = window_q[BITS*i + int'(bit_idx_q)];
         nz_s[i]    = |bus.weights[WB*i +: WB];
      end
      z_en_s = active_q & ~bit_b_s;
   end

   wos_weight_sum #(.N(N), .WB(WB)) u_total (
      .weights_i (bus.weights),
      .en_i      ({N{1'b1}}),
      .sum_o     (total_s)
   );

   // z = weight of surviving candidates whose current bit is 0
   wos_weight_sum #(.N(N), .WB(WB)) u_zero (
      .weights_i (weights_q),
      .en_i      (z_en_s),
      .sum_o     (z_s)
   );

   // Next-state and datapath update
   always_comb begin
      state_d    = state_q;
      window_d   = window_q;
      weights_d  = weights_q;
      r_d        = r_q;
      active_d   = active_q;
      bit_idx_d  = bit_idx_q;
      result_d   = result_q;
      out_data_d = out_data_q;
      out_err_d  = out_err_q;
      bit_res_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               window_d  = bus.window;
               weights_d = bus.weights;
               r_d       = bus.rank;
               result_d  = '0;
               if (bus.rank >= total_s) begin
                  active_d   = '0;
                  out_data_d = '0;
                  out_err_d  = 1'b1;
                  state_d    = ST_DONE;
               end else begin
                  active_d  = nz_s;
                  bit_idx_d = CW'(BITS - 1);
                  state_d   = ST_RUN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Rank falls among the zero-bit candidates, or skip past them
            if (r_q < z_s) begin
               bit_res_s = 1'b0;
               active_d  = active_q & ~bit_b_s;
            end else begin
               bit_res_s = 1'b1;
               r_d       = r_q - z_s;
               active_d  = active_q & bit_b_s;
            end
            result_d = {result_q[BITS-2:0], bit_res_s};
            if (bit_idx_q == '0) begin
               out_data_d = {result_q[BITS-2:0], bit_res_s};
               out_err_d  = 1'b0;
               state_d    = ST_DONE;
            end else begin
               bit_idx_d = bit_idx_q - 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         window_q   <= '0;
         weights_q  <= '0;
         r_q        <= '0;
         active_q   <= '0;
         bit_idx_q  <= '0;
         result_q   <= '0;
         out_data_q <= '0;
         out_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         window_q   <= window_d;
         weights_q  <= weights_d;
         r_q        <= r_d;
         active_q   <= active_d;
         bit_idx_q  <= bit_idx_d;
         result_q   <= result_d;
         out_data_q <= out_data_d;
         out_err_q  <= out_err_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.out_data  = out_data_q;
   assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_wos_rank_select.sv
// Self-checking bench for wos_rank_select: sort-based reference model, cycle compare
// process, directed literal cases, mid-run reset and randomized traffic.
module tb_wos_rank_select;

   localparam int BITS = 8;
   localparam int N    = 3;
   localparam int WB   = 4;
   localparam int SW   = 7;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total_cnt = 0;
   int   bad_cnt   = 0;

   always #5 clk = ~clk;

   wos_rank_select_if #(.BITS(BITS), .N(N), .WB(WB)) bus ();

   wos_rank_select #(.BITS(BITS), .N(N), .WB(WB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int ref_total(input logic [WB*N-1:0] wts);
      int s;
      s = 0;
      for (int i = 0; i < N; i++) s += int'(wts[WB*i +: WB]);
      return s;
   endfunction

   // Walk the unmasked samples in ascending value order, accumulating weight
   function automatic logic [BITS-1:0] ref_value(input logic [BITS*N-1:0] win,
                                                 input logic [WB*N-1:0] wts,
                                                 input logic [SW-1:0] rk);
      bit used [N];
      int cum;
      int best;
      cum = 0;
      for (int i = 0; i < N; i++) used[i] = 1'b0;
      if (int'(rk) >= ref_total(wts)) return '0;
      for (int k = 0; k < N; k++) begin
         best = -1;
         for (int i = 0; i < N; i++) begin
            if (!used[i] && wts[WB*i +: WB] != 0 &&
                (best < 0 || win[BITS*i +: BITS] < win[BITS*best +: BITS])) best = i;
         end
         if (best < 0) return '0;
         used[best] = 1'b1;
         cum += int'(wts[WB*best +: WB]);
         if (int'(rk) < cum) return win[BITS*best +: BITS];
      end
      return '0;
   endfunction

   // Protocol-level expectation: busy countdown, pending result, held result
   logic            m_valid;
   int              m_cnt;
   logic [BITS-1:0] m_data, m_pend;
   logic            m_err;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_valid <= 1'b0; m_cnt <= 0; m_data <= '0; m_pend <= '0; m_err <= 1'b0;
      end else if (m_valid) begin
         if (bus.out_ready) m_valid <= 1'b0;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_valid <= 1'b1; m_data <= m_pend; m_err <= 1'b0;
         end
      end else if (bus.in_valid) begin
         if (int'(bus.rank) >= ref_total(bus.weights)) begin
            m_valid <= 1'b1; m_err <= 1'b1; m_data <= '0;
         end else begin
            m_cnt  <= BITS;
            m_pend <= ref_value(bus.window, bus.weights, bus.rank);
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         check("in_ready", 32'(bus.in_ready), 32'(!m_valid && m_cnt == 0));
         check("out_valid", 32'(bus.out_valid), 32'(m_valid));
         if (m_valid) begin
            check("out_data", 32'(bus.out_data), 32'(m_data));
            check("out_err", 32'(bus.out_err), 32'(m_err));
         end
      end
   end

   task automatic txn(input logic [BITS*N-1:0] win, input logic [WB*N-1:0] wts,
                      input logic [SW-1:0] rk, input int hold,
                      output logic [BITS-1:0] data, output logic err, output int lat);
      int g;
      g = 0;
      while (!bus.in_ready && g < 100) begin
         @(negedge clk); g++;
      end
      check("ready_wait", 32'(bus.in_ready), 32'd1);
      bus.window = win; bus.weights = wts; bus.rank = rk; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         bus.window   = (BITS*N)'($urandom);
         bus.rank     = SW'($urandom);
         bus.in_valid = 1'($urandom);
         @(negedge clk); lat++;
      end
      bus.in_valid = 1'b0;
      check("valid_wait", 32'(bus.out_valid), 32'd1);
      data = bus.out_data;
      err  = bus.out_err;
      for (int h = 0; h < hold; h++) begin
         bus.in_valid = 1'b1;
         bus.window   = (BITS*N)'($urandom);
         @(negedge clk);
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
         check("hold_data", 32'(bus.out_data), 32'(data));
         check("hold_err", 32'(bus.out_err), 32'(err));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("valid_drop", 32'(bus.out_valid), 32'd0);
   endtask

   task automatic directed(input string name, input logic [BITS*N-1:0] win,
                           input logic [WB*N-1:0] wts, input logic [SW-1:0] rk,
                           input int hold, input logic [BITS-1:0] exp_d,
                           input logic exp_e, input int exp_lat);
      logic [BITS-1:0] d;
      logic            e;
      int              l;
      txn(win, wts, rk, hold, d, e, l);
      check({name, "_data"}, 32'(d), 32'(exp_d));
      check({name, "_err"}, 32'(e), 32'(exp_e));
      check({name, "_lat"}, 32'(l), 32'(exp_lat));
   endtask

   logic [BITS*N-1:0] w3;
   logic [BITS*N-1:0] wmax;

   initial begin
      logic [BITS*N-1:0] rw;
      logic [WB*N-1:0]   rwt;
      logic [SW-1:0]     rrk;
      logic [BITS-1:0]   d;
      logic            e;
      int              l;
      int              tot;
      int              quiet;

      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.window = '0; bus.weights = '0; bus.rank = '0;
      w3   = {8'd20, 8'd30, 8'd10};
      wmax = {8'd255, 8'd255, 8'd255};

      check("model_w111_r1", 32'(ref_value(w3, {4'd1, 4'd1, 4'd1}, 7'd1)), 32'd20);
      check("model_w113_r3", 32'(ref_value(w3, {4'd1, 4'd1, 4'd3}, 7'd3)), 32'd20);
      check("model_w110_r0", 32'(ref_value(w3, {4'd1, 4'd1, 4'd0}, 7'd0)), 32'd20);

      #12;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_out_err", 32'(bus.out_err), 32'd0);
      @(negedge clk); #2 rst = 1'b1;
      @(negedge clk);

      directed("eq_r1",   w3,   {4'd1, 4'd1, 4'd1}, 7'd1, 0, 8'd20,  1'b0, BITS);
      directed("w3_r2",   w3,   {4'd1, 4'd1, 4'd3}, 7'd2, 0, 8'd10,  1'b0, BITS);
      directed("w3_r3",   w3,   {4'd1, 4'd1, 4'd3}, 7'd3, 1, 8'd20,  1'b0, BITS);
      directed("w3_r4",   w3,   {4'd1, 4'd1, 4'd3}, 7'd4, 0, 8'd30,  1'b0, BITS);
      directed("mask0",   w3,   {4'd1, 4'd1, 4'd0}, 7'd0, 0, 8'd20,  1'b0, BITS);
      directed("allmask", w3,   {4'd0, 4'd0, 4'd0}, 7'd0, 0, 8'd0,   1'b1, 0);
      directed("max_r2",  wmax, {4'd1, 4'd1, 4'd1}, 7'd2, 0, 8'd255, 1'b0, BITS);
      directed("max_r3",  wmax, {4'd1, 4'd1, 4'd1}, 7'd3, 0, 8'd0,   1'b1, 0);
      directed("hold5",   w3,   {4'd1, 4'd1, 4'd1}, 7'd1, 5, 8'd20,  1'b0, BITS);

      // Reset pulsed while the selector is mid-run
      bus.window = w3; bus.weights = {4'd1, 4'd1, 4'd1}; bus.rank = 7'd2; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      #2 rst = 1'b1;
      quiet = 0;
      for (int c = 0; c < 2 * BITS; c++) begin
         @(negedge clk);
         if (bus.out_valid) quiet++;
      end
      check("midrst_no_output", 32'(quiet), 32'd0);
      directed("post_rst", w3, {4'd1, 4'd1, 4'd1}, 7'd2, 0, 8'd30, 1'b0, BITS);

      for (int t = 0; t < 150; t++) begin
         rw  = (BITS*N)'($urandom);
         if ($urandom_range(0, 3) == 0) rw[BITS +: BITS] = rw[0 +: BITS];
         if ($urandom_range(0, 7) == 0) rw = {BITS*N{1'b1}};
         for (int i = 0; i < N; i++) begin
            rwt[WB*i +: WB] = ($urandom_range(0, 3) == 0) ? 4'd0 : WB'($urandom);
         end
         tot = ref_total(rwt);
         rrk = SW'($urandom_range(0, tot + 1));
         txn(rw, rwt, rrk, int'($urandom_range(0, 3)), d, e, l);
         check("rnd_data", 32'(d), 32'(ref_value(rw, rwt, rrk)));
         check("rnd_err", 32'(e), 32'(int'(rrk) >= tot));
         check("rnd_lat", 32'(l), (int'(rrk) >= tot) ? 32'd0 : 32'(BITS));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
